date_bus_reader: RTL
====================

Name: date_bus_reader

Overview:
- Read-side master for the shared wired-OR date/time databus.
- Each counter (second, minute, hour, day, month) drives its value onto its databus output only while its enable is high, and drives zero otherwise. The block ORs these outputs into one bus.
- This block steps a one-hot enable across the sources, samples the bus and assembles a coherent snapshot for the display/formatter.
- Sits between the counter bank and the display path.

Parameters:
- NUM_SRC, 5, number of bus sources; index 0 = second … 4 = month.
- BUS_W, 6, databus width; narrower sources are zero-extended on the bus.
- SETTLE, 1, extra cycles enable is held before sampling (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  scan request; sampled in IDLE only.
- continuous  in  1  when high, a new scan begins automatically after each done.
- databus  in  BUS_W  OR of all source databus outputs.
- en  out  NUM_SRC  one-hot source enable (all zero when not driving).
- busy  out  1  high from scan start until done.
- done  out  1  one-cycle pulse, snapshot just updated.
- changed  out  1  valid with done: new snapshot differs from previous one.
- snapshot  out  NUM_SRC*BUS_W  source i at bits [i*BUS_W +: BUS_W].

Behaviour:
- Reset (clear high, async): state IDLE; en=0, busy=0, done=0, changed=0, snapshot=0, shadow=0, idx=0, settle counter=0.
  - Reset mid-scan aborts the scan immediately; en drops without waiting for a clock edge.
- States: IDLE, DRIVE, CAPTURE, DONE.
- IDLE:
  - Enter DRIVE on (start | continuous).
  - idx←0, settle counter←0, busy←1.
- DRIVE:
  - en = one-hot(idx).
  - If counter == SETTLE, go to CAPTURE; else counter+1.
  - With SETTLE=0, DRIVE lasts exactly 1 cycle.
- CAPTURE:
  - en still = one-hot(idx).
  - shadow[idx]←databus on this edge.
  - If idx==NUM_SRC-1, go to DONE; else idx+1, counter←0, go to DRIVE.
- DONE (1 cycle):
  - en=0.
  - snapshot←shadow, applied atomically.
  - changed←(shadow != old snapshot).
  - done=1, busy←0.
  - Next state is DRIVE if continuous, else IDLE. No gap cycle in continuous mode.
- Enable timing:
  - Enable per source is held SETTLE+2 cycles.
  - en is never multi-hot, and is never high in IDLE or DONE.
- Latency: start seen in IDLE → done pulse in cycle NUM_SRC*(SETTLE+2)+1 after the start edge. Default: 16.
- Bus capture: the bus is registered raw.
  - Bits above a source's natural width are stored as received. No masking, no range check.
- Output stability: snapshot changes only in DONE; it is stable between done pulses, including throughout a scan.
- Start handling:
  - start while busy is ignored; it is not queued.
  - start held high repeats scans, the same as continuous.
- continuous dropped mid-scan: the current scan completes, then the block returns to IDLE.
- done and changed are registered outputs, each high for exactly 1 cycle.
- changed on the first scan after reset compares against the all-zero snapshot.

Test Plan:
- Reset value:
  - Stimulus: assert clear, then release; hold start=0.
  - Required response: en=0, busy=0, done=0, snapshot=0 for 50 cycles.
- Single scan, defaults:
  - Stimulus: model the sources as sec=37, min=12, hour=9, day=28, month=12, each driving the bus only while its en bit is set; pulse start 1 cycle.
  - Required response: en walks 00001→10000, 3 cycles per source; done at cycle 16; snapshot fields = {12,28,9,12,37}; changed=1; busy falls with done.
- Repeat identical scan:
  - Stimulus: second start with the source values unchanged.
  - Required response: snapshot identical; changed=0 on done.
  - Stimulus: then set month=1 and start again.
  - Required response: only the month field = 1; changed=1.
- Continuous mode, SETTLE=0:
  - Stimulus: hold continuous=1.
  - Required response: done every 11 cycles, back-to-back; en never multi-hot; en=0 in each DONE cycle.
  - Stimulus: deassert continuous mid-scan.
  - Required response: one more done, then IDLE.
- Ignored start and coherence:
  - Stimulus: pulse start during the 3rd source of a scan.
  - Required response: no extra scan.
  - Stimulus: change sec from 37 to 38 after index 0 has been sampled.
  - Required response: snapshot holds 37 until the next scan; snapshot never updates before done.
- Reset mid-scan:
  - Stimulus: assert clear asynchronously (between clock edges) while en=00100.
  - Required response: en=0 and snapshot=0 before the next edge; after release the block waits in IDLE, and a new start gives a full 16-cycle scan.

Source files
------------

// File: rtl/date_bus_reader.sv
`default_nettype none
// ============================================================================
//  Module   : date_bus_reader
//  Purpose  : Read-side master for the shared wired-OR date/time databus.
//             It steps a one-hot enable across the counter sources, samples
//             the OR'ed bus and then publishes all fields as one coherent
//             snapshot.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         system clock, rising edge
//    clear_i       asynchronous active-high reset
//    start_i       scan request, sampled in IDLE only
//    continuous_i  start a new scan automatically after each done
//    databus_i     OR of all source databus outputs
//    en_o          one-hot source enable (zero when not driving)
//    busy_o        high from scan start until done
//    done_o        one-cycle pulse, snapshot just updated
//    changed_o     valid with done: new snapshot differs from previous one
//    snapshot_o    source i at bits [i*BUS_W +: BUS_W]
// ============================================================================
module date_bus_reader #(
  parameter int NUM_SRC = 5,
  parameter int BUS_W   = 6,
  parameter int SETTLE  = 1
) (
  input  logic                       clk_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic                       continuous_i,
  input  logic [BUS_W-1:0]           databus_i,
  output logic [NUM_SRC-1:0]         en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       changed_o,
  output logic [NUM_SRC*BUS_W-1:0]   snapshot_o
);

  localparam int                  IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_SRC - 1);
  localparam logic [3:0]          SETTLE_CNT = 4'(SETTLE);
  localparam logic [NUM_SRC-1:0]  EN_FIRST   = NUM_SRC'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [3:0]                 cnt_q;
  logic [NUM_SRC-1:0]         en_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       changed_q;
  logic [NUM_SRC*BUS_W-1:0]   shadow_q;
  logic [NUM_SRC*BUS_W-1:0]   snapshot_q;
  logic [NUM_SRC*BUS_W-1:0]   snapshot_d;

  // The last field is captured on the same edge that publishes the snapshot,
  // so the published value takes it straight from the bus rather than from
  // the shadow register (which only updates on that same edge).
  always_comb begin
    snapshot_d = shadow_q;
    snapshot_d[(NUM_SRC-1)*BUS_W +: BUS_W] = databus_i;
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      changed_q  <= 1'b0;
      shadow_q   <= '0;
      snapshot_q <= '0;
    end else begin
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i | continuous_i) begin
            state_q <= S_DRIVE;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= EN_FIRST;
            busy_q  <= 1'b1;
          end
        end

        S_DRIVE: begin
          if (cnt_q == SETTLE_CNT) begin
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_CAPTURE: begin
          shadow_q[int'(idx_q)*BUS_W +: BUS_W] <= databus_i;
          if (idx_q == LAST_IDX) begin
            // Entering DONE: publish everything atomically, drop the enable.
            state_q    <= S_DONE;
            en_q       <= '0;
            snapshot_q <= snapshot_d;
            changed_q  <= (snapshot_d != snapshot_q);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= S_DRIVE;
            idx_q   <= idx_q + 1'b1;
            cnt_q   <= '0;
            en_q    <= en_q << 1;
          end
        end

        S_DONE: begin
          if (continuous_i) begin
            state_q <= S_DRIVE;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= EN_FIRST;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          en_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en_o       = en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign changed_o  = changed_q;
  assign snapshot_o = snapshot_q;

endmodule
`default_nettype wire
